// File: rtl/commit_mem_loadbuffer_ml_pkg.sv
// Shared types and address-split helpers for the commit-stage load buffer.
package commit_mem_loadbuffer_ml_pkg;

  localparam int unsigned AddrW = 32;

  typedef enum logic [1:0] {
    LineInvalid = 2'd0,
    LineFilling = 2'd1,
    LineDiscard = 2'd2,
    LineFilled  = 2'd3
  } line_state_e;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int unsigned tag_w(input int unsigned line_words);
    return AddrW - off_w(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/commit_mem_loadbuffer_line.sv
// One refill line: state FSM, tag and per-word valid bits, plus hit/busy/match flags.
module commit_mem_loadbuffer_line
  import commit_mem_loadbuffer_ml_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 8,
  localparam int unsigned TagW = tag_w(LINE_WORDS),
  localparam int unsigned IdxW = idx_w(LINE_WORDS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inv_all,
  input  logic            start,
  input  logic [TagW-1:0] start_tag,
  input  logic            we,
  input  logic [IdxW-1:0] widx,
  input  logic            done,
  input  logic            snp_valid,
  input  logic [TagW-1:0] snp_tag,
  input  logic [TagW-1:0] q_tag,
  input  logic [IdxW-1:0] q_widx,
  input  logic [TagW-1:0] s_tag,
  output logic            hit,
  output logic            busy,
  output logic            s_match,
  output logic            invalid,
  output logic            filling
);

  line_state_e           state_q;
  logic [TagW-1:0]       tag_q;
  logic [LINE_WORDS-1:0] wvalid_q;
  logic                  tag_live;
  logic                  snp_match;

  assign tag_live  = (state_q == LineFilling) || (state_q == LineFilled);
  assign snp_match = snp_valid && tag_live && (tag_q == snp_tag);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= LineInvalid;
      tag_q    <= '0;
      wvalid_q <= '0;
    end else if (inv_all) begin
      state_q  <= LineInvalid;
      wvalid_q <= '0;
    end else if (start) begin
      // A start overrides a same-cycle snoop against the old tag.
      state_q  <= LineFilling;
      tag_q    <= start_tag;
      wvalid_q <= '0;
    end else begin
      if (we && (state_q == LineFilling)) wvalid_q[widx] <= 1'b1;
      case (state_q)
        LineFilling: begin
          if (snp_match)  state_q <= done ? LineInvalid : LineDiscard;
          else if (done) state_q <= LineFilled;
        end
        LineDiscard: if (done) state_q <= LineInvalid;
        LineFilled:  if (snp_match) state_q <= LineInvalid;
        default: ;
      endcase
    end
  end

  assign hit     = tag_live && (tag_q == q_tag) && wvalid_q[q_widx];
  assign busy    = (state_q == LineFilling) || (state_q == LineDiscard);
  assign s_match = tag_live && (tag_q == s_tag);
  assign invalid = (state_q == LineInvalid);
  assign filling = (state_q == LineFilling);

endmodule

// File: rtl/commit_mem_loadbuffer_ml.sv
// Commit-stage load buffer: refill lines with word-granular hits plus an uncached capture slot.
module commit_mem_loadbuffer_ml
  import commit_mem_loadbuffer_ml_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 4,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned UNC_HOLD   = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             unc_we,
  input  logic [AddrW-1:0] unc_addr,
  input  logic [31:0]      unc_din,
  input  logic             unc_clr,
  input  logic             fill_start,
  input  logic [AddrW-1:0] fill_addr,
  output logic             fill_ready,
  input  logic             fill_we,
  input  logic [AddrW-1:0] fill_waddr,
  input  logic [31:0]      fill_din,
  input  logic             fill_done,
  input  logic             inv_all,
  input  logic             snp_valid,
  input  logic [AddrW-1:0] snp_addr,
  input  logic [AddrW-1:0] s_qaddr,
  output logic             s_busy,
  output logic             s_qhit,
  input  logic [AddrW-1:0] qaddr,
  output logic             qhit,
  output logic [31:0]      qdata
);

  localparam int unsigned OffW = off_w(LINE_WORDS);
  localparam int unsigned TagW = tag_w(LINE_WORDS);
  localparam int unsigned IdxW = idx_w(LINE_WORDS);
  localparam int unsigned PtrW = $clog2(NUM_LINES);

  logic [NUM_LINES-1:0] line_hit, line_busy, line_smatch, line_invalid, line_filling;
  logic [PtrW-1:0]      rr_q, cur_q, victim, hit_idx;
  logic                 use_rr, start_acc, line_any;
  logic [31:0]          line_data;
  logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
  logic [IdxW-1:0]      fill_widx, q_widx;
  logic                 unc_valid_q, unc_valid_d, unc_hit;
  logic [AddrW-1:0]     unc_addr_q;
  logic [31:0]          unc_data_q;

  assign fill_widx  = fill_waddr[OffW-1:2];
  assign q_widx     = qaddr[OffW-1:2];
  assign s_busy     = |line_busy;
  assign fill_ready = ~s_busy;
  assign s_qhit     = |line_smatch;
  // A start colliding with fill_done is illegal and dropped.
  assign start_acc  = fill_start && fill_ready && !fill_done && !inv_all;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    commit_mem_loadbuffer_line #(
      .LINE_WORDS(LINE_WORDS)
    ) u_line (
      .clk      (clk),
      .resetn   (resetn),
      .inv_all  (inv_all),
      .start    (start_acc && (victim == PtrW'(i))),
      .start_tag(fill_addr[AddrW-1:OffW]),
      .we       (fill_we && (cur_q == PtrW'(i))),
      .widx     (fill_widx),
      .done     (fill_done && (cur_q == PtrW'(i))),
      .snp_valid(snp_valid),
      .snp_tag  (snp_addr[AddrW-1:OffW]),
      .q_tag    (qaddr[AddrW-1:OffW]),
      .q_widx   (q_widx),
      .s_tag    (s_qaddr[AddrW-1:OffW]),
      .hit      (line_hit[i]),
      .busy     (line_busy[i]),
      .s_match  (line_smatch[i]),
      .invalid  (line_invalid[i]),
      .filling  (line_filling[i])
    );
  end

  always_comb begin
    victim = rr_q;
    use_rr = 1'b1;
    for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
      if (line_invalid[i]) begin
        victim = PtrW'(i);
        use_rr = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q  <= '0;
      cur_q <= '0;
    end else if (start_acc) begin
      cur_q <= victim;
      if (use_rr) rr_q <= rr_q + 1'b1;
    end
  end

  // Data array is intentionally not reset; word valids guard every read.
  always_ff @(posedge clk) begin
    if (fill_we && !inv_all && line_filling[cur_q]) data_q[cur_q][fill_widx] <= fill_din;
  end

  always_comb begin
    line_any = 1'b0;
    hit_idx  = '0;
    for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
      if (line_hit[i]) begin
        line_any = 1'b1;
        hit_idx  = PtrW'(i);
      end
    end
    line_data = data_q[hit_idx][q_widx];
  end

  assign unc_valid_d = (UNC_HOLD != 0) ? (unc_we | (unc_valid_q & ~unc_clr)) : unc_we;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      unc_valid_q <= 1'b0;
      unc_addr_q  <= '0;
      unc_data_q  <= '0;
    end else begin
      unc_valid_q <= unc_valid_d;
      if (unc_we) begin
        unc_addr_q <= unc_addr;
        unc_data_q <= unc_din;
      end
    end
  end

  assign unc_hit = unc_valid_q && (unc_addr_q == qaddr);
  assign qhit    = unc_hit | line_any;
  assign qdata   = unc_hit ? unc_data_q : line_data;

  logic unused_bits;
  assign unused_bits = ^{fill_addr[OffW-1:0], fill_waddr[AddrW-1:OffW], fill_waddr[1:0],
                         qaddr[1:0], snp_addr[OffW-1:0], s_qaddr[OffW-1:0]};

endmodule

// File: tb/tb_commit_mem_loadbuffer_ml.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs for two DUTs
// (UNC_HOLD=0 and UNC_HOLD=1) driven by the same directed and random stimulus.
module tb_commit_mem_loadbuffer_ml;

  localparam int NL = 4;
  localparam int LW = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        unc_we, unc_clr, fill_start, fill_we, fill_done, inv_all, snp_valid;
  logic [31:0] unc_addr, unc_din, fill_addr, fill_waddr, fill_din, snp_addr, s_qaddr, qaddr;
  logic        fill_ready0, s_busy0, s_qhit0, qhit0;
  logic        fill_ready1, s_busy1, s_qhit1, qhit1;
  logic [31:0] qdata0, qdata1;

  always #5 clk = ~clk;

  commit_mem_loadbuffer_ml #(.NUM_LINES(NL), .LINE_WORDS(LW), .UNC_HOLD(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .unc_we(unc_we), .unc_addr(unc_addr), .unc_din(unc_din),
    .unc_clr(unc_clr), .fill_start(fill_start), .fill_addr(fill_addr), .fill_ready(fill_ready0),
    .fill_we(fill_we), .fill_waddr(fill_waddr), .fill_din(fill_din), .fill_done(fill_done),
    .inv_all(inv_all), .snp_valid(snp_valid), .snp_addr(snp_addr), .s_qaddr(s_qaddr),
    .s_busy(s_busy0), .s_qhit(s_qhit0), .qaddr(qaddr), .qhit(qhit0), .qdata(qdata0)
  );

  commit_mem_loadbuffer_ml #(.NUM_LINES(NL), .LINE_WORDS(LW), .UNC_HOLD(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .unc_we(unc_we), .unc_addr(unc_addr), .unc_din(unc_din),
    .unc_clr(unc_clr), .fill_start(fill_start), .fill_addr(fill_addr), .fill_ready(fill_ready1),
    .fill_we(fill_we), .fill_waddr(fill_waddr), .fill_din(fill_din), .fill_done(fill_done),
    .inv_all(inv_all), .snp_valid(snp_valid), .snp_addr(snp_addr), .s_qaddr(s_qaddr),
    .s_busy(s_busy1), .s_qhit(s_qhit1), .qaddr(qaddr), .qhit(qhit1), .qdata(qdata1)
  );

  typedef struct packed {
    logic        fr;
    logic        sb;
    logic        sq;
    logic [1:0]  qh;
    logic [31:0] qd0;
    logic [31:0] qd1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   drv_done = 1'b0;

  // Model: 0 invalid, 1 filling, 2 discard, 3 filled.
  int          m_st[NL];
  logic [26:0] m_tag[NL];
  bit          m_val[NL][LW];
  logic [31:0] m_dat[NL][LW];
  int          m_rr;
  bit          m_uv[2];
  logic [31:0] m_ua, m_ud;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_st[i] = 0;
      for (int w = 0; w < LW; w++) m_val[i][w] = 1'b0;
    end
    m_rr = 0;
    m_uv[0] = 1'b0;
    m_uv[1] = 1'b0;
  endtask

  task automatic model_step();
    int  old[NL];
    int  active;
    int  vic;
    bit  start_ok;
    bit  snooped;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (unc_we) begin
      m_ua = unc_addr;
      m_ud = unc_din;
    end
    m_uv[0] = unc_we;
    m_uv[1] = unc_we || (m_uv[1] && !unc_clr);
    if (inv_all) begin
      for (int i = 0; i < NL; i++) begin
        m_st[i] = 0;
        for (int w = 0; w < LW; w++) m_val[i][w] = 1'b0;
      end
      return;
    end
    active = -1;
    for (int i = 0; i < NL; i++) begin
      old[i] = m_st[i];
      if (m_st[i] == 1 || m_st[i] == 2) active = i;
    end
    start_ok = fill_start && (active < 0) && !fill_done;
    if (active >= 0 && old[active] == 1 && fill_we) begin
      m_dat[active][fill_waddr[4:2]] = fill_din;
      m_val[active][fill_waddr[4:2]] = 1'b1;
    end
    for (int i = 0; i < NL; i++) begin
      snooped = snp_valid && (old[i] == 1 || old[i] == 3) && (m_tag[i] == snp_addr[31:5]);
      if (old[i] == 1) begin
        if (snooped) m_st[i] = fill_done ? 0 : 2;
        else if (fill_done) m_st[i] = 3;
      end else if (old[i] == 2 && fill_done) begin
        m_st[i] = 0;
      end else if (old[i] == 3 && snooped) begin
        m_st[i] = 0;
      end
    end
    if (start_ok) begin
      vic = -1;
      for (int i = NL - 1; i >= 0; i--) if (old[i] == 0) vic = i;
      if (vic < 0) begin
        vic  = m_rr;
        m_rr = (m_rr + 1) % NL;
      end
      m_st[vic]  = 1;
      m_tag[vic] = fill_addr[31:5];
      for (int w = 0; w < LW; w++) m_val[vic][w] = 1'b0;
    end
  endtask

  function automatic exp_t predict();
    exp_t        e;
    bit          lh;
    bit          uh;
    logic [31:0] ld;
    e.fr = 1'b1;
    e.sq = 1'b0;
    lh = 1'b0;
    ld = '0;
    for (int i = 0; i < NL; i++) begin
      if (m_st[i] == 1 || m_st[i] == 2) e.fr = 1'b0;
      if ((m_st[i] == 1 || m_st[i] == 3) && m_tag[i] == s_qaddr[31:5]) e.sq = 1'b1;
      if (!lh && (m_st[i] == 1 || m_st[i] == 3) && m_tag[i] == qaddr[31:5]
          && m_val[i][qaddr[4:2]]) begin
        lh = 1'b1;
        ld = m_dat[i][qaddr[4:2]];
      end
    end
    e.sb = !e.fr;
    uh = m_uv[0] && (m_ua == qaddr);
    e.qh[0] = uh || lh;
    e.qd0 = uh ? m_ud : ld;
    uh = m_uv[1] && (m_ua == qaddr);
    e.qh[1] = uh || lh;
    e.qd1 = uh ? m_ud : ld;
    return e;
  endfunction

  task automatic tick();
    if (!resetn) model_reset();
    exp_q.push_back(predict());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    fill_start = 0; fill_we = 0; fill_done = 0; inv_all = 0;
    snp_valid = 0; unc_we = 0; unc_clr = 0;
  endtask

  task automatic fill_line(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] q,
                           input int snp_beat);
    idle();
    fill_start = 1; fill_addr = a; qaddr = q;
    tick();
    idle();
    for (int w = 0; w < LW; w++) begin
      fill_we = 1; fill_waddr = a + 32'(4 * w); fill_din = d0 + 32'(w);
      fill_done = (w == LW - 1);
      snp_valid = (w == snp_beat); snp_addr = a + 32'h14;
      s_qaddr = a;
      tick();
    end
    idle();
    tick();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] bases [6];
    bases = '{32'h1000, 32'h1020, 32'h1040, 32'h1060, 32'h1080, 32'h2000};
    return bases[$urandom_range(0, 5)] + 32'(4 * $urandom_range(0, LW - 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_monitor();
    exp_t e;
    while (!(drv_done && exp_q.size() == 0)) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fill_ready0", 32'(fill_ready0), 32'(e.fr));
        chk("fill_ready1", 32'(fill_ready1), 32'(e.fr));
        chk("s_busy0", 32'(s_busy0), 32'(e.sb));
        chk("s_busy1", 32'(s_busy1), 32'(e.sb));
        chk("s_qhit0", 32'(s_qhit0), 32'(e.sq));
        chk("s_qhit1", 32'(s_qhit1), 32'(e.sq));
        chk("qhit_hold0", 32'(qhit0), 32'(e.qh[0]));
        chk("qhit_hold1", 32'(qhit1), 32'(e.qh[1]));
        if (e.qh[0]) chk("qdata_hold0", qdata0, e.qd0);
        if (e.qh[1]) chk("qdata_hold1", qdata1, e.qd1);
      end
    end
  endtask

  task automatic run_driver();
    resetn = 0;
    idle();
    unc_addr = '0; unc_din = '0; fill_addr = '0; fill_waddr = '0; fill_din = '0;
    snp_addr = '0; s_qaddr = 32'h1000; qaddr = 32'h1008;
    for (int i = 0; i < NL; i++) m_tag[i] = '0;
    m_ua = '0; m_ud = '0;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    resetn = 1;
    tick();
    // Fill with queries on word 2; then a fill aborted by reset after three beats.
    fill_line(32'h1000, 32'hA0, 32'h1008, -1);
    fill_start = 1; fill_addr = 32'h1020; qaddr = 32'h1024; s_qaddr = 32'h1020;
    tick();
    idle();
    for (int w = 0; w < 3; w++) begin
      fill_we = 1; fill_waddr = 32'h1020 + 32'(4 * w); fill_din = 32'hB0 + 32'(w);
      tick();
    end
    idle();
    resetn = 0;
    tick();
    resetn = 1;
    tick();
    // Snoop during a fill, then five lines into four entries.
    fill_line(32'h1000, 32'hC0, 32'h1004, 2);
    tick();
    for (int k = 0; k < 5; k++) fill_line(32'h1000 + 32'(k * 32), 32'h100 * 32'(k + 1), 32'h1000, -1);
    for (int k = 0; k < 5; k++) begin
      qaddr = 32'h1004 + 32'(k * 32);
      s_qaddr = 32'h1000 + 32'(k * 32);
      tick();
    end
    // inv_all with a colliding start.
    inv_all = 1; fill_start = 1; fill_addr = 32'h1040;
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      qaddr = 32'h1004 + 32'(k * 32);
      tick();
    end
    // Uncached capture over a filled line covering the same address.
    fill_line(32'h2000, 32'h5000, 32'h2000, -1);
    unc_we = 1; unc_addr = 32'h2000; unc_din = 32'hDEAD; qaddr = 32'h2000;
    tick();
    idle();
    repeat (10) tick();
    unc_clr = 1;
    tick();
    idle();
    repeat (2) tick();
    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      resetn      = ($urandom_range(0, 999) >= 3);
      fill_start  = ($urandom_range(0, 99) < 20);
      fill_addr   = rnd_addr();
      fill_we     = ($urandom_range(0, 99) < 60);
      fill_waddr  = rnd_addr();
      fill_din    = $urandom;
      fill_done   = ($urandom_range(0, 99) < 12);
      inv_all     = ($urandom_range(0, 99) < 1);
      snp_valid   = ($urandom_range(0, 99) < 5);
      snp_addr    = rnd_addr();
      unc_we      = ($urandom_range(0, 99) < 10);
      unc_addr    = rnd_addr();
      unc_din     = $urandom;
      unc_clr     = ($urandom_range(0, 99) < 15);
      s_qaddr     = rnd_addr();
      qaddr       = ($urandom_range(0, 99) < 25) ? m_ua : rnd_addr();
      tick();
    end
    resetn = 1;
    idle();
    tick();
    drv_done = 1'b1;
  endtask

  initial begin
    fork
      run_driver();
      run_monitor();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
